// File: rtl/bvh_pkg.sv
// bvh_pkg -- shared types for the BVH traversal slice.
//   ray_t   : [0] = origin, [1] = direction, three signed 32-bit coordinates each
//   box_t   : [0] = min corner, [1] = max corner
//   node_t  : BVH node as returned by node memory
//   state_t : traversal controller states
//   sat_inc16 : saturating 16-bit increment used by the optional statistics
package bvh_pkg;

  localparam int COORD_W = 32;

  typedef logic signed [0:1][0:2][COORD_W-1:0] ray_t;
  typedef logic signed [0:1][0:2][COORD_W-1:0] box_t;

  typedef struct packed {
    box_t        bbox;
    logic        is_leaf;
    logic [31:0] idx;      // left child (internal) or first triangle (leaf)
    logic [15:0] cnt;      // triangle count (leaf only)
  } node_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    TEST  = 3'd3,
    EMIT  = 3'd4,
    POP   = 3'd5
  } state_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bvh_stack.sv
// bvh_stack -- LIFO of deferred node addresses.
//   i_clear : drop all entries (synchronous)
//   i_push  : write i_data on top (ignored when full)
//   i_pop   : discard top entry (ignored when empty)
//   o_top   : current top entry (combinational)
//   o_full / o_empty : occupancy flags
module bvh_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-2:0] top_idx;

  assign o_full  = (ptr_q == PW'(DEPTH));
  assign o_empty = (ptr_q == '0);
  assign top_idx = ptr_q[PW-2:0] - (PW-1)'(1);
  assign o_top   = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (i_clear)                 ptr_d = '0;
    else if (i_push && !o_full)  ptr_d = ptr_q + PW'(1);
    else if (i_pop && !o_empty)  ptr_d = ptr_q - PW'(1);
    else                         ptr_d = ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Entry storage carries no reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (!i_clear && i_push && !o_full) mem_q[ptr_q[PW-2:0]] <= i_data;
  end

endmodule

// File: rtl/ray_intersect_box.sv
// ray_intersect_box -- combinational ray / axis-aligned box slab test.
//   i_ray : origin and direction, Q(32-FRA_BITS).FRA_BITS
//   i_box : min and max corners, same format
//   o_hit : ray (t >= 0) overlaps the box
// Parameters: FRA_BITS fractional bits of the entry/exit distances,
// SAT clamps those distances to 32 bits instead of wrapping.
module ray_intersect_box
  import bvh_pkg::*;
#(
  parameter int FRA_BITS = 16,
  parameter bit SAT      = 1'b1
) (
  input  ray_t i_ray,
  input  box_t i_box,
  output logic o_hit
);

  localparam logic signed [63:0] T_HI = 64'sd2147483647;
  localparam logic signed [63:0] T_LO = -64'sd2147483648;

  function automatic logic signed [63:0] sext(input logic [31:0] v);
    return $signed({{32{v[31]}}, v});
  endfunction

  // Bring a slab distance back into the 32-bit range.
  function automatic logic signed [63:0] fit(input logic signed [63:0] v);
    logic signed [63:0] r;
    if (SAT) begin
      if (v > T_HI)      r = T_HI;
      else if (v < T_LO) r = T_LO;
      else               r = v;
    end else begin
      r = sext(v[31:0]);
    end
    return r;
  endfunction

  logic signed [63:0] org_s, dir_s, lo_s, hi_s, t0_s, t1_s, t_near, t_far;
  logic               miss;

  // Per-axis slab intervals narrowed into one [t_near, t_far] window.
  always_comb begin
    t_near = T_LO;
    t_far  = T_HI;
    miss   = 1'b0;
    org_s  = '0;
    dir_s  = '0;
    lo_s   = '0;
    hi_s   = '0;
    t0_s   = '0;
    t1_s   = '0;
    for (int a = 0; a < 3; a++) begin
      org_s = sext(i_ray[0][a]);
      dir_s = sext(i_ray[1][a]);
      lo_s  = sext(i_box[0][a]);
      hi_s  = sext(i_box[1][a]);
      if (dir_s == 64'sd0) begin
        // Parallel to the slab: either always inside or never.
        t0_s = '0;
        t1_s = '0;
        if (org_s < lo_s || org_s > hi_s) miss = 1'b1;
      end else begin
        t0_s = fit(((lo_s - org_s) <<< FRA_BITS) / dir_s);
        t1_s = fit(((hi_s - org_s) <<< FRA_BITS) / dir_s);
        if (t0_s <= t1_s) begin
          if (t0_s > t_near) t_near = t0_s;
          if (t1_s < t_far)  t_far  = t1_s;
        end else begin
          if (t1_s > t_near) t_near = t1_s;
          if (t0_s < t_far)  t_far  = t0_s;
        end
      end
    end
    o_hit = !miss && (t_near <= t_far) && (t_far >= 64'sd0);
  end

endmodule

// File: rtl/bvh_traverse.sv
// bvh_traverse -- stack-based BVH traversal controller.
// Accepts a ray (i_valid/o_ready), walks the BVH from node 0 by issuing
// single-cycle node reads (o_node_rd/o_node_addr, reply on i_node_rdvalid),
// tests each box with ray_intersect_box, defers right children on
// bvh_stack and streams hit leaves (o_leaf_valid/i_leaf_ready with
// o_tri_base/o_tri_cnt). o_done pulses when the walk ends; o_overflow is
// sticky per ray when a deferred child had to be dropped.
// Optional macro BVH_STATS_EN adds o_nodes_visited / o_boxes_hit.
module bvh_traverse
  import bvh_pkg::*;
#(
  parameter int FRA_BITS    = 16,
  parameter bit SAT         = 1'b1,
  parameter int NODE_AW     = 12,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  ray_t               i_ray,
  output logic               o_node_rd,
  output logic [NODE_AW-1:0] o_node_addr,
  input  logic               i_node_rdvalid,
  input  node_t              i_node_data,
  output logic               o_leaf_valid,
  input  logic               i_leaf_ready,
  output logic [31:0]        o_tri_base,
  output logic [15:0]        o_tri_cnt,
  output logic               o_done,
  output logic               o_overflow
`ifdef BVH_STATS_EN
  ,
  output logic [15:0]        o_nodes_visited,
  output logic [15:0]        o_boxes_hit
`endif
);

  state_t             state_q, state_d;
  ray_t               ray_q, ray_d;
  node_t              node_q, node_d;
  logic               ready_q, ready_d;
  logic               node_rd_q, node_rd_d;
  logic [NODE_AW-1:0] node_addr_q, node_addr_d;
  logic               leaf_valid_q, leaf_valid_d;
  logic [31:0]        tri_base_q, tri_base_d;
  logic [15:0]        tri_cnt_q, tri_cnt_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
`ifdef BVH_STATS_EN
  logic [15:0]        visited_q, visited_d;
  logic [15:0]        boxes_q, boxes_d;
`endif

  logic               box_hit;
  logic               stk_clear, stk_push, stk_pop, stk_full, stk_empty;
  logic [NODE_AW-1:0] stk_wdata, stk_top;

  ray_intersect_box #(
    .FRA_BITS (FRA_BITS),
    .SAT      (SAT)
  ) u_isect (
    .i_ray (ray_q),
    .i_box (node_q.bbox),
    .o_hit (box_hit)
  );

  bvh_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (NODE_AW)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_clear (stk_clear),
    .i_push  (stk_push),
    .i_pop   (stk_pop),
    .i_data  (stk_wdata),
    .o_top   (stk_top),
    .o_full  (stk_full),
    .o_empty (stk_empty)
  );

  // Right child is always the node after the left child, wrapping in NODE_AW.
  assign stk_wdata = node_q.idx[NODE_AW-1:0] + NODE_AW'(1);

  // Next-state and next-output decode. Read request and address are
  // produced on entry to FETCH, so FETCH itself lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    ray_d       = ray_q;
    node_d      = node_q;
    tri_base_d  = tri_base_q;
    tri_cnt_d   = tri_cnt_q;
    overflow_d  = overflow_q;
    node_rd_d   = 1'b0;
    node_addr_d = '0;
    done_d      = 1'b0;
    stk_clear   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`ifdef BVH_STATS_EN
    visited_d   = visited_q;
    boxes_d     = boxes_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          ray_d      = i_ray;
          stk_clear  = 1'b1;
          overflow_d = 1'b0;
          node_rd_d  = 1'b1;
          state_d    = FETCH;
`ifdef BVH_STATS_EN
          visited_d  = '0;
          boxes_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (i_node_rdvalid) begin
          node_d  = i_node_data;
          state_d = TEST;
        end else begin
          state_d = WAIT;
        end
      end
      TEST: begin
`ifdef BVH_STATS_EN
        visited_d = sat_inc16(visited_q);
        if (box_hit) boxes_d = sat_inc16(boxes_q);
        else         boxes_d = boxes_q;
`endif
        if (!box_hit || (node_q.is_leaf && node_q.cnt == 16'd0)) begin
          state_d = POP;
          done_d  = stk_empty;
        end else if (node_q.is_leaf) begin
          tri_base_d = node_q.idx;
          tri_cnt_d  = node_q.cnt;
          state_d    = EMIT;
        end else begin
          // Full stack: the right subtree is lost but the walk goes on.
          if (stk_full) overflow_d = 1'b1;
          else          stk_push   = 1'b1;
          node_addr_d = node_q.idx[NODE_AW-1:0];
          node_rd_d   = 1'b1;
          state_d     = FETCH;
        end
      end
      EMIT: begin
        if (i_leaf_ready) begin
          state_d = POP;
          done_d  = stk_empty;
        end else begin
          state_d = EMIT;
        end
      end
      POP: begin
        if (!stk_empty) begin
          stk_pop     = 1'b1;
          node_addr_d = stk_top;
          node_rd_d   = 1'b1;
          state_d     = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    leaf_valid_d = (state_d == EMIT);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ray_q        <= '0;
      node_q       <= '0;
      ready_q      <= 1'b1;
      node_rd_q    <= 1'b0;
      node_addr_q  <= '0;
      leaf_valid_q <= 1'b0;
      tri_base_q   <= '0;
      tri_cnt_q    <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef BVH_STATS_EN
      visited_q    <= '0;
      boxes_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ray_q        <= ray_d;
      node_q       <= node_d;
      ready_q      <= ready_d;
      node_rd_q    <= node_rd_d;
      node_addr_q  <= node_addr_d;
      leaf_valid_q <= leaf_valid_d;
      tri_base_q   <= tri_base_d;
      tri_cnt_q    <= tri_cnt_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
`ifdef BVH_STATS_EN
      visited_q    <= visited_d;
      boxes_q      <= boxes_d;
`endif
    end
  end

  assign o_ready      = ready_q;
  assign o_node_rd    = node_rd_q;
  assign o_node_addr  = node_addr_q;
  assign o_leaf_valid = leaf_valid_q;
  assign o_tri_base   = tri_base_q;
  assign o_tri_cnt    = tri_cnt_q;
  assign o_done       = done_q;
  assign o_overflow   = overflow_q;
`ifdef BVH_STATS_EN
  assign o_nodes_visited = visited_q;
  assign o_boxes_hit     = boxes_q;
`endif

endmodule
